hd44780_ctrl: RTL and testbench
===============================

HD44780_CTRL -- requirements
Module: hd44780_ctrl

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, clock frequency in Hz; all delays are derived from it.
REQ-002 Parameter LINE_LEN, default 16, characters per display line.
REQ-003 Port clk, input, 1, single clock; all logic is on its rising edge.
REQ-004 Port rstb, input, 1, asynchronous active-low reset.
REQ-005 Port char_in, input, 8, ASCII character to display.
REQ-006 Port char_valid, input, 1, char_in is valid.
REQ-007 Port clear_req, input, 1, request a display clear and cursor home.
REQ-008 Port char_ready, output, 1, block can accept a character this cycle.
REQ-009 Port busy, output, 1, initialisation or a bus transfer is in progress.
REQ-010 Port lcd_data, output, 8, LCD DB7..DB0.
REQ-011 Port lcd_rs, output, 1, 0 = command, 1 = data.
REQ-012 Port lcd_rw, output, 1, held at 0 (write only).
REQ-013 Port lcd_en, output, 1, LCD enable strobe.

Function
REQ-014 Timing constants: T_PWR=CLK_FREQ/50 (20 ms); T_CLR=CLK_FREQ/500 (2 ms); T_CMD=CLK_FREQ/20000 (50 us); T_EN=max(CLK_FREQ/2_000_000,1) (500 ns); T_SU=1 cycle.
REQ-015 FSM states: PWR_WAIT, INIT, IDLE, SETUP, EN_HI, HOLD, EXEC_WAIT.
REQ-016 After reset, PWR_WAIT counts T_PWR cycles, then moves to INIT.
REQ-017 INIT issues, in order: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06, all with rs=0; each transfer completes before the next starts.
REQ-018 Each transfer runs SETUP (lcd_data/lcd_rs stable, en=0, T_SU) -> EN_HI (en=1, T_EN) -> HOLD (en=0, 1 cycle) -> EXEC_WAIT (T_CLR for 0x01, T_CMD otherwise).
REQ-019 lcd_data and lcd_rs change only in SETUP entry, never while lcd_en=1.
REQ-020 char_ready=1 only in IDLE after INIT completes, and only while clear_req=0.
REQ-021 A character is accepted when char_valid && char_ready; char_in is latched that cycle; char_ready=0 the next cycle.
REQ-022 Cursor state: col (0..LINE_LEN) and line (0..1) registers.
REQ-023 A printable character (0x20-0x7E) is written with rs=1; col increments.
REQ-024 Wrap: if col==LINE_LEN when a printable character is accepted, first issue a set-address command, then write the character at col 0 (col becomes 1).
  - Address command is 0xC0 if line=0, else 0x80.
  - line toggles on wrap.
REQ-025 Newline 0x0A: issue the set-address command for the other line, set col=0, toggle line; nothing is written.
REQ-026 Other non-printables are accepted and discarded; no bus transfer occurs.
REQ-027 clear_req in IDLE issues 0x01 (T_CLR wait) and sets col=0, line=0.
REQ-028 Simultaneous clear_req and char_valid: clear wins and the character is not accepted.
REQ-029 clear_req outside IDLE is level-held by the requester and is not lost; it is serviced on the next IDLE cycle.
REQ-030 busy=1 in every state except IDLE.

Reset
REQ-031 rstb low asynchronously forces: state=PWR_WAIT, lcd_data=0, lcd_rs=0, lcd_rw=0, lcd_en=0, char_ready=0, busy=1, col=0, line=0, and clears counters.
REQ-032 Reset asserted mid-transfer aborts the transfer immediately (lcd_en=0) and restarts the full power-on sequence.

Structure
REQ-033 Package lcd_pkg holds the FSM state enum, the LCD command constants (0x38, 0x0C, 0x01, 0x06, 0x80, 0xC0) and the init command table.
REQ-034 One sub-module, lcd_delay_timer: loadable down-counter with load value and done pulse, sized for T_PWR.
REQ-035 All outputs are registered.

Verification
REQ-036 Run with CLK_FREQ=1_000_000 and a behavioural HD44780 model.
REQ-037 Release reset: no lcd_en edge for 20000 cycles; then exactly 6 en pulses with data 38,38,38,0C,01,06; then char_ready=1.
REQ-038 Send 'A' (0x41): one pulse with rs=1, data=0x41, en high for 1 cycle; char_ready returns after 50 cycles.
REQ-039 Send 17 chars: a command 0xC0 precedes char 17; the model shows char 17 at line 2, col 0.
REQ-040 Send 0x0A after 3 chars: one command 0xC0 and no data write; the next char lands at line 2, col 0.
REQ-041 Assert clear_req and char_valid together: only 0x01 is sent; char_ready stays 0 for 2000 cycles; the character is not consumed.
REQ-042 Pulse rstb low while lcd_en=1: lcd_en falls in the same cycle and the init sequence repeats from PWR_WAIT.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types, LCD command bytes and the power-on command table for the
// HD44780 character-LCD controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT,
    IDLE,
    SETUP,
    EN_HI,
    HOLD,
    EXEC_WAIT
  } lcd_state_e;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_LINE0    = 8'h80;
  localparam logic [7:0] CMD_LINE1    = 8'hC0;
  localparam logic [7:0] CHAR_NL      = 8'h0A;

  localparam int INIT_LEN = 6;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    logic [7:0] cmd;
    case (idx)
      3'd0, 3'd1, 3'd2: cmd = CMD_FUNC_SET;
      3'd3:             cmd = CMD_DISP_ON;
      3'd4:             cmd = CMD_CLEAR;
      default:          cmd = CMD_ENTRY;
    endcase
    return cmd;
  endfunction

  // Set-address command that moves the cursor to column 0 of the other line.
  function automatic logic [7:0] other_line_cmd(input logic line);
    return line ? CMD_LINE0 : CMD_LINE1;
  endfunction

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

  function automatic int at_least_one(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter. done_o is high during the last counted cycle, so a
// load of N keeps the caller in a state for exactly N cycles.
module lcd_delay_timer #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             done_o,
  output logic             idle_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign done_o = (cnt_q == WIDTH'(1));
  assign idle_o = (cnt_q == '0);

endmodule

// File: rtl/hd44780_ctrl.sv
// HD44780 character-LCD controller: power-on init, character streaming with
// line wrap and newline, and display clear over an 8-bit write-only bus.
//
// state     | meaning
// PWR_WAIT  | waiting for the LCD supply to settle after reset
// INIT      | selecting the next power-on command
// IDLE      | ready for a character or a clear request
// SETUP     | data/rs presented, enable low
// EN_HI     | enable strobe high
// HOLD      | enable low, data still held
// EXEC_WAIT | waiting for the LCD to execute the transfer
module hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int LINE_LEN = 16
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  input  logic       clear_req,
  output logic       char_ready,
  output logic       busy,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en
);

  localparam int T_PWR = at_least_one(CLK_FREQ / 50);
  localparam int T_CLR = at_least_one(CLK_FREQ / 500);
  localparam int T_CMD = at_least_one(CLK_FREQ / 20_000);
  localparam int T_EN  = at_least_one(CLK_FREQ / 2_000_000);
  localparam int TW    = $clog2(T_PWR + 1);
  localparam int CW    = $clog2(LINE_LEN + 1);

  localparam logic [TW-1:0] LD_PWR = TW'(T_PWR);
  localparam logic [TW-1:0] LD_CLR = TW'(T_CLR);
  localparam logic [TW-1:0] LD_CMD = TW'(T_CMD);
  localparam logic [TW-1:0] LD_EN  = TW'(T_EN);
  localparam logic [CW-1:0] COL_END = CW'(LINE_LEN);

  lcd_state_e      state_q, state_d;
  logic [7:0]      data_q, data_d;
  logic            rs_q, rs_d;
  logic            en_q, ready_q, busy_q;
  logic [CW-1:0]   col_q, col_d;
  logic            line_q, line_d;
  logic [2:0]      init_idx_q, init_idx_d;
  logic            init_done_q, init_done_d;
  logic            pend_q, pend_d;
  logic [7:0]      pend_char_q, pend_char_d;
  logic            accept;
  logic            tmr_load, tmr_done, tmr_idle;
  logic [TW-1:0]   tmr_val;

  lcd_delay_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .rstb       (rstb),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done),
    .idle_o     (tmr_idle)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    rs_d        = rs_q;
    col_d       = col_q;
    line_d      = line_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    pend_d      = pend_q;
    pend_char_d = pend_char_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    accept      = 1'b0;

    case (state_q)
      PWR_WAIT: begin
        if (tmr_done) begin
          state_d = INIT;
        end else if (tmr_idle) begin
          tmr_load = 1'b1;
          tmr_val  = LD_PWR;
        end
      end
      INIT: begin
        state_d    = SETUP;
        data_d     = init_cmd(init_idx_q);
        rs_d       = 1'b0;
        init_idx_d = init_idx_q + 3'd1;
      end
      IDLE: begin
        // Clear has priority; a character offered in the same cycle stays pending.
        if (clear_req) begin
          state_d = SETUP;
          data_d  = CMD_CLEAR;
          rs_d    = 1'b0;
          col_d   = '0;
          line_d  = 1'b0;
        end else if (char_valid && ready_q) begin
          accept = 1'b1;
          if (is_printable(char_in)) begin
            state_d = SETUP;
            if (col_q == COL_END) begin
              data_d      = other_line_cmd(line_q);
              rs_d        = 1'b0;
              line_d      = ~line_q;
              col_d       = CW'(1);
              pend_d      = 1'b1;
              pend_char_d = char_in;
            end else begin
              data_d = char_in;
              rs_d   = 1'b1;
              col_d  = col_q + CW'(1);
            end
          end else if (char_in == CHAR_NL) begin
            state_d = SETUP;
            data_d  = other_line_cmd(line_q);
            rs_d    = 1'b0;
            line_d  = ~line_q;
            col_d   = '0;
          end
        end
      end
      SETUP: begin
        state_d  = EN_HI;
        tmr_load = 1'b1;
        tmr_val  = LD_EN;
      end
      EN_HI: begin
        if (tmr_done) state_d = HOLD;
      end
      HOLD: begin
        state_d  = EXEC_WAIT;
        tmr_load = 1'b1;
        tmr_val  = (!rs_q && data_q == CMD_CLEAR) ? LD_CLR : LD_CMD;
      end
      EXEC_WAIT: begin
        if (tmr_done) begin
          if (!init_done_q) begin
            if (init_idx_q == 3'(INIT_LEN)) begin
              init_done_d = 1'b1;
              state_d     = IDLE;
            end else begin
              state_d = INIT;
            end
          end else if (pend_q) begin
            // Second half of a wrap: the address command went out, now the character.
            state_d = SETUP;
            data_d  = pend_char_q;
            rs_d    = 1'b1;
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= PWR_WAIT;
      data_q      <= '0;
      rs_q        <= 1'b0;
      en_q        <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      col_q       <= '0;
      line_q      <= 1'b0;
      init_idx_q  <= '0;
      init_done_q <= 1'b0;
      pend_q      <= 1'b0;
      pend_char_q <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      en_q        <= (state_d == EN_HI);
      ready_q     <= (state_d == IDLE) && !accept && !clear_req;
      busy_q      <= (state_d != IDLE);
      col_q       <= col_d;
      line_q      <= line_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      pend_q      <= pend_d;
      pend_char_q <= pend_char_d;
    end
  end

  assign lcd_data   = data_q;
  assign lcd_rs     = rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_en     = en_q;
  assign char_ready = ready_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_hd44780_ctrl.sv
// Scoreboard bench for hd44780_ctrl at 1 MHz with a behavioural HD44780
// DDRAM model and a cursor-level reference model.
module tb_hd44780_ctrl;

  localparam int CLK_FREQ = 1_000_000;
  localparam int LINE_LEN = 16;
  localparam int T_PWR = 20000;
  localparam int T_CLR = 2000;
  localparam int T_CMD = 50;
  localparam int T_EN  = 1;

  logic       clk = 1'b0;
  logic       rstb;
  logic [7:0] char_in;
  logic       char_valid, clear_req;
  logic       char_ready, busy;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en;

  hd44780_ctrl #(.CLK_FREQ(CLK_FREQ), .LINE_LEN(LINE_LEN)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .char_in    (char_in),
    .char_valid (char_valid),
    .clear_req  (clear_req),
    .char_ready (char_ready),
    .busy       (busy),
    .lcd_data   (lcd_data),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_en     (lcd_en)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel_cyc = 0;

  logic [8:0] exp_q[$];
  logic [7:0] hd_ram[128];
  logic [6:0] hd_ac = '0;
  logic [7:0] ref_scr[128];
  int         ref_col;
  bit         ref_line;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // ---------------- reference cursor model ----------------
  task automatic ref_clear();
    for (int i = 0; i < 128; i++) ref_scr[i] = 8'h20;
    ref_col  = 0;
    ref_line = 1'b0;
  endtask

  task automatic ref_push(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      if (ref_col == LINE_LEN) begin
        exp_q.push_back({1'b0, ref_line ? 8'h80 : 8'hC0});
        ref_line = !ref_line;
        ref_col  = 0;
      end
      exp_q.push_back({1'b1, c});
      ref_scr[(ref_line ? 64 : 0) + ref_col] = c;
      ref_col++;
    end else if (c == 8'h0A) begin
      exp_q.push_back({1'b0, ref_line ? 8'h80 : 8'hC0});
      ref_line = !ref_line;
      ref_col  = 0;
    end
  endtask

  task automatic push_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h006);
    ref_clear();
  endtask

  // ---------------- HD44780 behavioural model ----------------
  task automatic hd_apply(input logic [8:0] w);
    if (w[8]) begin
      hd_ram[hd_ac] = w[7:0];
      hd_ac = hd_ac + 7'd1;
    end else if (w[7]) begin
      hd_ac = w[6:0];
    end else if (w[7:0] == 8'h01) begin
      for (int i = 0; i < 128; i++) hd_ram[i] = 8'h20;
      hd_ac = '0;
    end
  endtask

  // ---------------- bus monitor ----------------
  logic       en_prev = 1'b0;
  bit         have_fall = 1'b0;
  bit         last_clear = 1'b0;
  int         rise_cyc, fall_cyc;
  logic [8:0] rise_word, exp_w;

  always @(negedge clk) begin
    cyc++;
    if (!rstb) begin
      en_prev   = 1'b0;
      have_fall = 1'b0;
    end else begin
      if (lcd_en && !en_prev) begin
        rise_cyc  = cyc;
        rise_word = {lcd_rs, lcd_data};
        check("lcd_rw_low", lcd_rw, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got %03h expected none", rise_word);
        end else begin
          exp_w = exp_q.pop_front();
          check("xfer_word", rise_word, exp_w);
        end
        checks++;
        if (have_fall) begin
          if (cyc - fall_cyc < (last_clear ? T_CLR : T_CMD)) begin
            errors++;
            $display("FAIL exec_gap: got %0d cycles expected >= %0d", cyc - fall_cyc,
                     last_clear ? T_CLR : T_CMD);
          end
        end else if (cyc - rel_cyc < T_PWR) begin
          errors++;
          $display("FAIL pwr_wait: got %0d cycles expected >= %0d", cyc - rel_cyc, T_PWR);
        end
      end
      if (!lcd_en && en_prev) begin
        fall_cyc   = cyc;
        have_fall  = 1'b1;
        last_clear = (rise_word == 9'h001);
        check("en_width", cyc - rise_cyc, T_EN);
        check("data_stable", {lcd_rs, lcd_data}, rise_word);
        hd_apply(rise_word);
      end
      en_prev = lcd_en;
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic wait_ready(input int max_cyc, input string name, output int n);
    n = 0;
    while (!char_ready && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no char_ready expected within %0d cycles", name, max_cyc);
    end
  endtask

  task automatic send_char(input logic [7:0] c);
    int n;
    wait_ready(3000, "send", n);
    char_in    = c;
    char_valid = 1'b1;
    ref_push(c);
    @(negedge clk);
    char_valid = 1'b0;
    check("ready_drop", char_ready, 0);
  endtask

  task automatic do_clear();
    int n;
    wait_ready(3000, "clear", n);
    clear_req = 1'b1;
    exp_q.push_back(9'h001);
    ref_clear();
    @(negedge clk);
    clear_req = 1'b0;
    check("clear_ready_low", char_ready, 0);
  endtask

  function automatic logic [7:0] rand_printable();
    return 8'($urandom_range(8'h20, 8'h7E));
  endfunction

  task automatic check_screen(input string name);
    for (int i = 0; i < LINE_LEN; i++) begin
      check(name, hd_ram[i], ref_scr[i]);
      check(name, hd_ram[64 + i], ref_scr[64 + i]);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [7:0] c;
    rstb = 1'b0; char_in = '0; char_valid = 1'b0; clear_req = 1'b0;
    for (int i = 0; i < 128; i++) hd_ram[i] = 8'h20;
    ref_clear();
    repeat (3) @(negedge clk);
    check("rst_en", lcd_en, 0);
    check("rst_busy", busy, 1);
    check("rst_ready", char_ready, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_data", lcd_data, 0);
    check("rst_rw", lcd_rw, 0);

    rstb = 1'b1;
    rel_cyc = cyc;
    push_init();
    wait_ready(25000, "init", n);
    check("init_drained", exp_q.size(), 0);
    check("idle_not_busy", busy, 0);

    send_char(8'h41);
    wait_ready(3000, "char_a", n);
    checks++;
    if (n < T_CMD || n > T_CMD + 10) begin
      errors++;
      $display("FAIL char_a_latency: got %0d cycles expected %0d..%0d", n, T_CMD, T_CMD + 10);
    end
    check("char_a_ram", hd_ram[0], 8'h41);

    do_clear();
    for (int i = 0; i < 17; i++) send_char(rand_printable());
    wait_ready(3000, "wrap", n);
    check("wrap_line2_col0", hd_ram[64], ref_scr[64]);
    check_screen("wrap_screen");

    do_clear();
    for (int i = 0; i < 3; i++) send_char(rand_printable());
    send_char(8'h0A);
    c = rand_printable();
    send_char(c);
    wait_ready(3000, "newline", n);
    check("nl_line2_col0", hd_ram[64], c);
    check("nl_ac", hd_ac, 7'h41);

    // clear raised while a transfer is in flight, held until taken in IDLE
    send_char(rand_printable());
    clear_req = 1'b1;
    exp_q.push_back(9'h001);
    ref_clear();
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("held_clear_idle", busy, 0);
    @(negedge clk);
    clear_req = 1'b0;
    wait_ready(3000, "held_clear", n);
    check("held_clear_drained", exp_q.size(), 0);

    // clear and character offered together: clear wins, character waits
    send_char(rand_printable());
    wait_ready(3000, "pre_collide", n);
    c = rand_printable();
    char_in = c; char_valid = 1'b1; clear_req = 1'b1;
    exp_q.push_back(9'h001);
    ref_clear();
    @(negedge clk);
    clear_req = 1'b0;
    wait_ready(3000, "collide", n);
    checks++;
    if (n < T_CLR) begin
      errors++;
      $display("FAIL collide_ready_low: got %0d cycles expected >= %0d", n, T_CLR);
    end
    check("collide_char_kept", hd_ram[0], 8'h20);
    ref_push(c);
    @(negedge clk);
    char_valid = 1'b0;
    wait_ready(3000, "collide_after", n);
    check("collide_char_late", hd_ram[0], c);

    // randomized mix of printable, newline and discarded characters
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0:       c = 8'h0A;
        1:       c = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom_range(8'h7F, 8'hFF));
        default: c = rand_printable();
      endcase
      send_char(c);
    end
    wait_ready(3000, "random", n);
    check("random_drained", exp_q.size(), 0);
    check_screen("random_screen");

    // reset during an enable pulse
    send_char(8'h5A);
    n = 0;
    while (!lcd_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_saw_en", lcd_en, 1);
    rstb = 1'b0;
    #1;
    check("abort_en_low", lcd_en, 0);
    check("abort_busy", busy, 1);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b1;
    rel_cyc = cyc;
    push_init();
    wait_ready(25000, "reinit", n);
    check("reinit_drained", exp_q.size(), 0);
    send_char(8'h42);
    wait_ready(3000, "post_reset", n);
    check("post_reset_ram", hd_ram[0], 8'h42);
    check("final_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
